// File: rtl/mux_nto1_stream.sv
// Registered N-to-1 stream multiplexer with manual or round-robin channel selection.
// Define MUX_NTO1_SEL_CHECK_EN to make err_o flag out-of-range manual selects (sticky until reset).
module mux_nto1_stream #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned SEL_W  = $clog2(NUM_CH)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    mode_i,
    input  logic [SEL_W-1:0]        sel_i,
    input  logic [NUM_CH*WIDTH-1:0] data_i,
    input  logic [NUM_CH-1:0]       valid_i,
    output logic [NUM_CH-1:0]       ready_o,
    output logic [WIDTH-1:0]        data_o,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic [SEL_W-1:0]        ch_o,
    output logic                    err_o
);

    logic [SEL_W-1:0] ptr_q;
    logic [WIDTH-1:0] data_q;
    logic [SEL_W-1:0] ch_q;
    logic             valid_q;

    logic             load_c;
    logic             man_vld_c;
    logic             rr_vld_c;
    logic [SEL_W-1:0] rr_idx_c;
    logic             gnt_vld_c;
    logic [SEL_W-1:0] gnt_c;
    logic [WIDTH-1:0] gnt_data_c;
    logic             xfer_c;

    // Output register accepts a beat when empty or draining this cycle.
    assign load_c = !valid_q || ready_i;

    // Manual select: comparing against each legal index keeps out-of-range selects grant-free.
    always_comb begin
        man_vld_c = 1'b0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (sel_i == SEL_W'(k) && valid_i[k]) begin
                man_vld_c = 1'b1;
            end
        end
    end

    // Round-robin: first valid channel starting at ptr+1, wrapping modulo NUM_CH.
    always_comb begin
        int unsigned pos;
        pos      = 0;
        rr_vld_c = 1'b0;
        rr_idx_c = '0;
        for (int unsigned i = 1; i <= NUM_CH; i++) begin
            pos = 32'(ptr_q) + i;
            if (pos >= NUM_CH) begin
                pos = pos - NUM_CH;
            end
            if (!rr_vld_c && valid_i[SEL_W'(pos)]) begin
                rr_vld_c = 1'b1;
                rr_idx_c = SEL_W'(pos);
            end
        end
    end

    assign gnt_vld_c = mode_i ? rr_vld_c : man_vld_c;
    assign gnt_c     = mode_i ? rr_idx_c : sel_i;
    assign xfer_c    = load_c && gnt_vld_c;

    always_comb begin
        gnt_data_c = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (gnt_c == SEL_W'(k)) begin
                gnt_data_c = data_i[k*WIDTH +: WIDTH];
            end
        end
    end

    // Ready is forced low while reset is asserted.
    always_comb begin
        ready_o = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            ready_o[k] = rst_ni && xfer_c && (gnt_c == SEL_W'(k));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ch_q    <= '0;
            ptr_q   <= SEL_W'(NUM_CH - 1);
        end else if (xfer_c) begin
            valid_q <= 1'b1;
            data_q  <= gnt_data_c;
            ch_q    <= gnt_c;
            if (mode_i) begin
                ptr_q <= gnt_c;
            end
        end else if (ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign data_o  = data_q;
    assign ch_o    = ch_q;
    assign valid_o = valid_q;

`ifdef MUX_NTO1_SEL_CHECK_EN
    logic err_q;
    logic sel_bad_c;

    assign sel_bad_c = !mode_i && (|valid_i) && !(32'(sel_i) < NUM_CH);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else if (sel_bad_c) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_mux_nto1_stream.sv
// Self-checking bench for mux_nto1_stream: spec-level model compared every cycle plus directed literal checks.
module tb_mux_nto1_stream;

    localparam int unsigned N  = 4;
    localparam int unsigned W  = 8;
    localparam int unsigned SW = 2;

`ifdef MUX_NTO1_SEL_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic            mode;
    logic [SW-1:0]   sel;
    logic [N*W-1:0]  data;
    logic [N-1:0]    valid;
    logic [N-1:0]    ready_o;
    logic [W-1:0]    data_o;
    logic            valid_o;
    logic            ready;
    logic [SW-1:0]   ch_o;
    logic            err_o;

    mux_nto1_stream #(.NUM_CH(N), .WIDTH(W)) dut (
        .clk_i(clk), .rst_ni(rst_n), .mode_i(mode), .sel_i(sel),
        .data_i(data), .valid_i(valid), .ready_o(ready_o), .data_o(data_o),
        .valid_o(valid_o), .ready_i(ready), .ch_o(ch_o), .err_o(err_o)
    );

    // Three-channel instance exercising the select-range check.
    logic        mode3;
    logic [1:0]  sel3;
    logic [23:0] data3;
    logic [2:0]  valid3;
    logic [2:0]  ready3_o;
    logic [7:0]  data3_o;
    logic        valid3_o;
    logic [1:0]  ch3_o;
    logic        err3_o;

    mux_nto1_stream #(.NUM_CH(3), .WIDTH(8)) dut3 (
        .clk_i(clk), .rst_ni(rst_n), .mode_i(mode3), .sel_i(sel3),
        .data_i(data3), .valid_i(valid3), .ready_o(ready3_o), .data_o(data3_o),
        .valid_o(valid3_o), .ready_i(ready), .ch_o(ch3_o), .err_o(err3_o)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Grant rule: returns granted channel or -1.
    function automatic int model_grant(input logic md, input int s, input logic [N-1:0] v, input int p);
        if (!md) begin
            if (s < int'(N)) begin
                if (v[s]) return s;
            end
            return -1;
        end
        for (int k = 1; k <= int'(N); k++) begin
            int c;
            c = (p + k) % int'(N);
            if (v[c]) return c;
        end
        return -1;
    endfunction

    logic          m_valid;
    logic [W-1:0]  m_data;
    logic [SW-1:0] m_ch;
    int            m_ptr;

    always @(posedge clk or negedge rst_n) begin
        int g;
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_ch    <= '0;
            m_ptr   <= int'(N) - 1;
        end else begin
            g = model_grant(mode, int'(sel), valid, m_ptr);
            if ((!m_valid || ready) && g >= 0) begin
                m_valid <= 1'b1;
                m_data  <= data[g*W +: W];
                m_ch    <= SW'(g);
                if (mode) m_ptr <= g;
            end else if (m_valid && ready) begin
                m_valid <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        logic [N-1:0] er;
        int g;
        er = '0;
        if (rst_n) begin
            g = model_grant(mode, int'(sel), valid, m_ptr);
            if ((!m_valid || ready) && g >= 0) er[g] = 1'b1;
        end
        chk("model_valid_o", 32'(valid_o), 32'(m_valid));
        chk("model_data_o", 32'(data_o), 32'(m_data));
        chk("model_ch_o", 32'(ch_o), 32'(m_ch));
        chk("model_ready_o", 32'(ready_o), 32'(er));
        chk("model_err_o", 32'(err_o), 32'(0));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int rr_exp [6];
        int bp_sel [3];
        rr_exp = '{0, 1, 2, 3, 0, 1};
        bp_sel = '{0, 1, 3};

        rst_n  = 1'b0;
        mode   = 1'b0;
        sel    = '0;
        valid  = '0;
        ready  = 1'b1;
        data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        mode3  = 1'b0;
        sel3   = '0;
        valid3 = '0;
        data3  = {8'hB2, 8'hB1, 8'hB0};

        repeat (2) @(posedge clk);
        #1;
        valid = '1;
        #1;
        chk("rst_ready_o", 32'(ready_o), 32'(0));
        chk("rst_valid_o", 32'(valid_o), 32'(0));
        chk("rst_data_o", 32'(data_o), 32'(0));
        chk("rst_ch_o", 32'(ch_o), 32'(0));
        chk("rst_err_o", 32'(err_o), 32'(0));
        rst_n = 1'b1;

        // Manual sweep
        for (int s = 0; s < 4; s++) begin
            sel = SW'(s);
            #1;
            chk("man_ready_o", 32'(ready_o), 32'(1) << s);
            step();
            chk("man_data_o", 32'(data_o), 32'(8'hA0 + s));
            chk("man_ch_o", 32'(ch_o), 32'(s));
            chk("man_valid_o", 32'(valid_o), 32'(1));
        end

        // Round-robin from reset
        pulse_reset();
        mode = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("rr_ch_o", 32'(ch_o), 32'(rr_exp[i]));
            chk("rr_valid_o", 32'(valid_o), 32'(1));
        end

        // Round-robin skipping idle channels
        pulse_reset();
        valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("skip_ready_o02", 32'({ready_o[2], ready_o[0]}), 32'(0));
            step();
            chk("skip_ch_o", 32'(ch_o), (i % 2 == 0) ? 32'(1) : 32'(3));
        end

        // Backpressure hold and same-edge reload
        mode  = 1'b0;
        valid = '1;
        sel   = 2'd2;
        step();
        chk("bp_load_data_o", 32'(data_o), 32'(8'hA2));
        ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sel = SW'(bp_sel[i]);
            #1;
            chk("bp_ready_o", 32'(ready_o), 32'(0));
            step();
            chk("bp_hold_data_o", 32'(data_o), 32'(8'hA2));
            chk("bp_hold_ch_o", 32'(ch_o), 32'(2));
            chk("bp_hold_valid_o", 32'(valid_o), 32'(1));
        end
        ready = 1'b1;
        sel   = 2'd3;
        #1;
        chk("bp_release_ready_o", 32'(ready_o), 32'(4'b1000));
        step();
        chk("bp_release_data_o", 32'(data_o), 32'(8'hA3));
        chk("bp_release_valid_o", 32'(valid_o), 32'(1));

        // Reset mid-stream
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid_o", 32'(valid_o), 32'(0));
        chk("mid_rst_data_o", 32'(data_o), 32'(0));
        chk("mid_rst_ch_o", 32'(ch_o), 32'(0));
        rst_n = 1'b1;
        mode  = 1'b1;
        #1;
        chk("mid_rst_ready_o", 32'(ready_o), 32'(4'b0001));
        step();
        chk("mid_rst_first_ch_o", 32'(ch_o), 32'(0));
        chk("mid_rst_first_data_o", 32'(data_o), 32'(8'hA0));

        // Out-of-range select on the three-channel instance
        chk("sel3_err_initial", 32'(err3_o), 32'(0));
        sel3   = 2'd3;
        valid3 = 3'b111;
        #1;
        chk("sel3_ready_o", 32'(ready3_o), 32'(0));
        step();
        chk("sel3_err_o", 32'(err3_o), 32'(EXP_ERR));
        chk("sel3_valid_o", 32'(valid3_o), 32'(0));
        sel3 = 2'd0;
        step();
        chk("sel3_err_sticky", 32'(err3_o), 32'(EXP_ERR));
        chk("sel3_data_o", 32'(data3_o), 32'(8'hB0));
        chk("sel3_ch_o", 32'(ch3_o), 32'(0));
        step();
        chk("sel3_err_sticky2", 32'(err3_o), 32'(EXP_ERR));

        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
